// File: rtl/sram_word_bridge_pkg.sv
// Shared types and constants for the 8-to-16 bit SRAM word bridge.
// State encoding, default phase timing and bus widths live here.
package sram_bridge_pkg;

    localparam int unsigned ADDR_W  = 22;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned WADDR_W = ADDR_W - 1;

    localparam int unsigned DEF_SETUP_CYC = 1;
    localparam int unsigned DEF_PULSE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_word_bridge_phase_cnt.sv
// Loadable down-counter timing one SRAM cycle phase.
// tc_o is high while the count is zero, i.e. in the last cycle of a phase.
module sram_phase_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sram_word_bridge.sv
// Byte req/ack port to 16-bit async SRAM with setup/strobe/hold timing.
// Optional one-word read buffer enabled by SRAM_READ_CACHE_EN.
module sram_word_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic               clk_chipset,
    input  logic               reset,
    input  logic               req,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               ack,
    output logic               busy,
    output logic [WADDR_W-1:0] ram_addr_o,
    output logic               ram_ce_n_o,
    output logic               ram_oe_n_o,
    output logic               ram_we_n_o,
    output logic               ram_lb_n_o,
    output logic               ram_ub_n_o,
    output logic [WORD_W-1:0]  ram_data_o,
    output logic               ram_data_oe,
    input  logic [WORD_W-1:0]  ram_data_i
);

    localparam int unsigned CNT_W =
        $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic               lane_q, lane_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               lb_n_q, lb_n_d;
    logic               ub_n_q, ub_n_d;
    logic               doe_q, doe_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;

    logic               cnt_ld;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_tc;
    logic               hit;
    logic [7:0]         hit_byte;

    sram_phase_cnt #(.W(CNT_W)) u_cnt (
        .clk_i      (clk_chipset),
        .rst_i      (reset),
        .load_i     (cnt_ld),
        .load_val_i (cnt_val),
        .tc_o       (cnt_tc)
    );

`ifdef SRAM_READ_CACHE_EN
    logic [WORD_W-1:0]  buf_q, buf_d;
    logic [WADDR_W-1:0] tag_q, tag_d;
    logic               vld_q, vld_d;

    assign hit      = vld_q && (tag_q == addr[ADDR_W-1:1]);
    assign hit_byte = addr[0] ? buf_q[15:8] : buf_q[7:0];

    // Fill on read completion; merge the written lane on a same-word write.
    always_comb begin
        buf_d = buf_q;
        tag_d = tag_q;
        vld_d = vld_q;
        if (state_q == ST_STROBE && cnt_tc && !we_q) begin
            buf_d = ram_data_i;
            tag_d = addr_q;
            vld_d = 1'b1;
        end
        if (state_q == ST_HOLD && cnt_tc && we_q
            && vld_q && tag_q == addr_q) begin
            if (lane_q) buf_d[15:8] = data_q[15:8];
            else        buf_d[7:0]  = data_q[7:0];
        end
    end

    // Buffer registers; reset invalidates the entry.
    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
            tag_q <= '0;
            vld_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            tag_q <= tag_d;
            vld_q <= vld_d;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_byte = 8'h00;
`endif

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        lb_n_d  = lb_n_q;
        ub_n_d  = ub_n_q;
        doe_d   = doe_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        cnt_ld  = 1'b0;
        cnt_val = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d   = we;
                    lane_d = addr[0];
                    busy_d = 1'b1;
                    if (!we && hit) begin
                        rdata_d = hit_byte;
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr[ADDR_W-1:1];
                        if (we) data_d = {wdata, wdata};
                        ce_n_d  = 1'b0;
                        lb_n_d  = addr[0];
                        ub_n_d  = ~addr[0];
                        doe_d   = we;
                        oe_n_d  = we;
                        state_d = ST_SETUP;
                        cnt_ld  = 1'b1;
                        cnt_val = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_tc) begin
                    we_n_d  = ~we_q;
                    state_d = ST_STROBE;
                    cnt_ld  = 1'b1;
                    cnt_val = CNT_W'(PULSE_CYC - 1);
                end
            end
            ST_STROBE: begin
                if (cnt_tc) begin
                    we_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = lane_q ? ram_data_i[15:8]
                                         : ram_data_i[7:0];
                    end
                    state_d = ST_HOLD;
                    cnt_ld  = 1'b1;
                    cnt_val = CNT_W'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_tc) begin
                    ce_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    doe_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops all strobes at once.
    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            lane_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            doe_q   <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
            doe_q   <= doe_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign rdata       = rdata_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign ram_addr_o  = addr_q;
    assign ram_ce_n_o  = ce_n_q;
    assign ram_oe_n_o  = oe_n_q;
    assign ram_we_n_o  = we_n_q;
    assign ram_lb_n_o  = lb_n_q;
    assign ram_ub_n_o  = ub_n_q;
    assign ram_data_o  = data_q;
    assign ram_data_oe = doe_q;

endmodule

// File: tb/tb_sram_word_bridge.sv
// Scoreboard bench for sram_word_bridge with a 16-word SRAM model.
// Build with +define+SRAM_READ_CACHE_EN to exercise the read buffer.
module tb_sram_word_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [21:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        ack, busy;
    logic [20:0] ram_addr_o;
    logic        ram_ce_n_o, ram_oe_n_o, ram_we_n_o;
    logic        ram_lb_n_o, ram_ub_n_o;
    logic [15:0] ram_data_o;
    logic        ram_data_oe;
    logic [15:0] ram_data_i;

    sram_word_bridge dut (
        .clk_chipset (clk),
        .reset       (rst),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ack         (ack),
        .busy        (busy),
        .ram_addr_o  (ram_addr_o),
        .ram_ce_n_o  (ram_ce_n_o),
        .ram_oe_n_o  (ram_oe_n_o),
        .ram_we_n_o  (ram_we_n_o),
        .ram_lb_n_o  (ram_lb_n_o),
        .ram_ub_n_o  (ram_ub_n_o),
        .ram_data_o  (ram_data_o),
        .ram_data_oe (ram_data_oe),
        .ram_data_i  (ram_data_i)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic        strobe;
        logic [20:0] waddr;
        logic        lb_n;
        logic        ub_n;
        logic [15:0] wd;
        logic [7:0]  rd;
        int          lat;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

`ifdef SRAM_READ_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic [15:0] mem [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic w, input logic s,
                                input logic [20:0] wa, input logic lb,
                                input logic ub, input logic [15:0] wd,
                                input logic [7:0] rd, input int lat,
                                input int gap);
        exp_t e;
        e.is_wr = w;  e.strobe = s; e.waddr = wa;
        e.lb_n = lb;  e.ub_n = ub;  e.wd = wd;
        e.rd = rd;    e.lat = lat;  e.gap = gap;
        return e;
    endfunction

    always_comb ram_data_i = ram_oe_n_o ? 16'h0000 : mem[ram_addr_o[3:0]];

    // SRAM model: preload on reset, lane-merged writes while we_n is low.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
                mem[0] = 16'hA55A;
                mem[8] = 16'h1234;
            end else if (!ram_we_n_o && !ram_ce_n_o) begin
                if (!ram_lb_n_o) mem[ram_addr_o[3:0]][7:0]  = ram_data_o[7:0];
                if (!ram_ub_n_o) mem[ram_addr_o[3:0]][15:8] = ram_data_o[15:8];
            end
        end
    end

    // Monitor: tracks each transaction and pops the scoreboard on ack.
    initial begin
        int          cyc, wecnt, gap, rec_gap;
        logic        in_tx, ce_seen;
        logic [20:0] s_addr;
        logic        s_lb, s_ub;
        logic [15:0] s_d;
        exp_t        e;
        in_tx = 1'b0; gap = -1; rec_gap = -1;
        cyc = 0; wecnt = 0; ce_seen = 1'b0;
        s_addr = '0; s_lb = 1'b1; s_ub = 1'b1; s_d = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_tx = 1'b0;
                gap   = -1;
            end else begin
                chk("we_oe_overlap", {31'd0, !ram_we_n_o && !ram_oe_n_o}, 0);
                chk("doe_oe_overlap", {31'd0, ram_data_oe && !ram_oe_n_o}, 0);
                if (!in_tx && busy) begin
                    in_tx = 1'b1; cyc = 0; wecnt = 0; ce_seen = 1'b0;
                    s_addr = ram_addr_o; s_lb = ram_lb_n_o;
                    s_ub = ram_ub_n_o; s_d = ram_data_o;
                    rec_gap = gap;
                end
                if (!in_tx && !busy && gap >= 0) gap++;
                if (in_tx) begin
                    cyc++;
                    if (!ram_we_n_o) wecnt++;
                    if (!ram_ce_n_o) ce_seen = 1'b1;
                end
                if (ack) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ack: got ack=1 want none");
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc, e.lat);
                        if (e.gap >= 0) chk("idle_gap", rec_gap, e.gap);
                        if (e.strobe) begin
                            chk("ram_addr", {11'd0, s_addr}, {11'd0, e.waddr});
                            chk("lb_n", {31'd0, s_lb}, {31'd0, e.lb_n});
                            chk("ub_n", {31'd0, s_ub}, {31'd0, e.ub_n});
                            chk("ce_active", {31'd0, ce_seen}, 1);
                            chk("we_pulse", wecnt, e.is_wr ? 2 : 0);
                        end else begin
                            chk("ce_idle_on_hit", {31'd0, ce_seen}, 0);
                        end
                        if (e.is_wr) chk("ram_data", {16'd0, s_d}, {16'd0, e.wd});
                        else         chk("rdata", {24'd0, rdata}, {24'd0, e.rd});
                    end
                    in_tx = 1'b0;
                    gap   = 0;
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [21:0] a,
                         input logic [7:0] d, input exp_t e);
        sb.push_back(e);
        req = 1'b1; we = w; addr = a; wdata = d;
    endtask

    task automatic wait_ack(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 40);
        total++;
        if (!ack) begin
            bad++;
            $display("FAIL %s_timeout: got ack=0 want 1", nm);
        end
    endtask

    task automatic idle1();
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_ce_n", {31'd0, ram_ce_n_o}, 1);
        chk("rst_oe_n", {31'd0, ram_oe_n_o}, 1);
        chk("rst_we_n", {31'd0, ram_we_n_o}, 1);
        chk("rst_lb_n", {31'd0, ram_lb_n_o}, 1);
        chk("rst_ub_n", {31'd0, ram_ub_n_o}, 1);
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_doe", {31'd0, ram_data_oe}, 0);
        chk("rst_addr", {11'd0, ram_addr_o}, 0);
        chk("rst_data", {16'd0, ram_data_o}, 0);
        chk("rst_rdata", {24'd0, rdata}, 0);

        issue(1, 22'h000001, 8'hA5,
              mk(1, 1, 21'h0, 1, 0, 16'hA5A5, 8'h00, 5, -1));
        wait_ack("wr_a5"); idle1();
        issue(0, 22'h000001, 8'h00,
              mk(0, 1, 21'h0, 1, 0, 16'h0, 8'hA5, 5, -1));
        wait_ack("rd_hi"); idle1();
        issue(0, 22'h000000, 8'h00,
              mk(0, 1, 21'h0, 0, 1, 16'h0, 8'h5A, 5, -1));
        wait_ack("rd_lo"); idle1();

        issue(1, 22'h3FFFFE, 8'h3C,
              mk(1, 1, 21'h1FFFFF, 0, 1, 16'h3C3C, 8'h00, 5, -1));
        wait_ack("b2b_wr");
        issue(0, 22'h3FFFFE, 8'h00,
              mk(0, 1, 21'h1FFFFF, 0, 1, 16'h0, 8'h3C, 5, 1));
        wait_ack("b2b_rd"); idle1();

        req = 1'b1; we = 1'b1; addr = 22'h000006; wdata = 8'h11;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ram_we_n_o && n < 20);
        chk("reach_strobe", {31'd0, ram_we_n_o}, 0);
        rst = 1'b1;
        #1;
        chk("abort_we_n", {31'd0, ram_we_n_o}, 1);
        chk("abort_ce_n", {31'd0, ram_ce_n_o}, 1);
        chk("abort_ack", {31'd0, ack}, 0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(0, 22'h000000, 8'h00,
              mk(0, 1, 21'h0, 0, 1, 16'h0, 8'h5A, 5, -1));
        wait_ack("post_rst_rd"); idle1();

        issue(0, 22'h000010, 8'h00,
              mk(0, 1, 21'h8, 0, 1, 16'h0, 8'h34, 5, -1));
        wait_ack("c_rd1"); idle1();
        issue(0, 22'h000010, 8'h00,
              mk(0, !CACHE, 21'h8, 0, 1, 16'h0, 8'h34, CACHE ? 1 : 5, -1));
        wait_ack("c_rd2"); idle1();
        issue(1, 22'h000011, 8'h77,
              mk(1, 1, 21'h8, 1, 0, 16'h7777, 8'h00, 5, -1));
        wait_ack("c_wr"); idle1();
        issue(0, 22'h000011, 8'h00,
              mk(0, !CACHE, 21'h8, 1, 0, 16'h0, 8'h77, CACHE ? 1 : 5, -1));
        wait_ack("c_rd3"); idle1();

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_word_bridge.md
Name: sram_word_bridge

Overview:
- Sits between the chipset's 8-bit byte-addressed SRAM port and the board's 16-bit asynchronous SRAM (21-bit word address, LB/UB byte enables).
- Converts a req/ack byte transaction into a timed SRAM cycle: setup, strobe and hold phases, with correct lane selection.
- Lets the system use both halves of the physical SRAM (4 MB) instead of parking UB high and leaving data[15:8] unused.

Parameters:
- SETUP_CYC, 1, cycles that address, CE and byte enables are valid before WE/OE sampling; min 1.
- PULSE_CYC, 2, cycles WE is low (write) or OE is active before data capture (read); min 1.
- HOLD_CYC, 1, cycles address and data are held after the strobe ends; min 1.

Ports:
- clk_chipset  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  transaction request; held high until ack.
- we  in  1  1 = write, 0 = read; sampled with req in IDLE.
- addr  in  22  byte address; [21:1] is the word address, [0] is the lane (0 = low).
- wdata  in  8  write byte.
- rdata  out  8  read byte, valid in the ack cycle and held until the next read completes.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- ram_addr_o  out  21  SRAM word address.
- ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_lb_n_o, ram_ub_n_o  out  1 each  SRAM controls, active low.
- ram_data_o  out  16  write data; the byte is replicated on both lanes.
- ram_data_oe  out  1  tristate enable for the top-level inout.
- ram_data_i  in  16  SRAM read data.

Behaviour:
- Clock and reset: one clock (clk_chipset); reset is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - ack, busy and ram_data_oe are 0.
  - All *_n outputs are 1.
  - ram_addr_o, ram_data_o and rdata are 0.
- Reset mid-transaction aborts immediately: the strobes deassert asynchronously and no ack is issued.
- All outputs are registered.
- States: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
- IDLE: when req is 1, capture we, addr and wdata, drive the address, ce_n=0 and the lane enable (lb_n=addr[0], ub_n=~addr[0]), then go to SETUP.
- SETUP: lasts SETUP_CYC cycles.
  - Write: ram_data_oe=1.
  - Read: oe_n=0.
- STROBE: lasts PULSE_CYC cycles.
  - Write: we_n=0.
  - Read: oe_n stays 0; on the last STROBE cycle, rdata <= addr[0] ? ram_data_i[15:8] : ram_data_i[7:0].
- HOLD: lasts HOLD_CYC cycles.
  - we_n=1, oe_n=1.
  - Address, data and ram_data_oe are held.
- DONE: ack=1 for one cycle; ce_n, lb_n and ub_n return to 1 and ram_data_oe to 0; next state is IDLE.
- Latency: req is sampled at edge N and ack is high in cycle N+SETUP_CYC+PULSE_CYC+HOLD_CYC+1. With defaults, ack is high 5 cycles after acceptance.
- Handshake rules:
  - The master deasserts req, or presents a new request, in the cycle after ack.
  - The bridge ignores req in the DONE cycle, so back-to-back transactions have one IDLE cycle between them.
  - Changes to addr, we or wdata while busy are ignored because the values are captured at acceptance.
- Invariants:
  - we_n and oe_n are never low in the same cycle.
  - ram_data_oe and oe_n=0 never coincide.
  - Phase counter width is clog2 of the maximum parameter plus 1; the counter reloads on every state entry.

Optional Feature:
- Macro: SRAM_READ_CACHE_EN.
- When defined, one 16-bit word buffer with a tag (word address) and a valid bit is added:
  - The buffer is filled on every completed read.
  - It is updated in place (lane merge) by a write to the same word.
  - It is invalidated by reset.
- A read hit in IDLE goes straight to DONE with no SRAM strobes, so ack arrives one cycle after acceptance.
- When the macro is undefined, every read performs the full SRAM cycle and no buffer logic exists.

Decomposition:
- Shared package sram_bridge_pkg holds:
  - the state encoding (IDLE, SETUP, STROBE, HOLD, DONE);
  - default timing constants;
  - the ADDR_W=22 and WORD_W=16 constants.
- One natural sub-module: sram_phase_cnt, a loadable down-counter with a terminal-count flag, used for each phase.

Test Plan:
- Reset held, then released with req=0 -> all *_n=1, ack=0, busy=0, ram_data_oe=0.
- Write addr=22'h000001, wdata=8'hA5 -> ram_addr_o=21'h0, ub_n=0, lb_n=1, ram_data_o=16'hA5A5, we_n low for exactly 2 cycles, ack at cycle 5.
- Read addr=22'h000001 with the SRAM model holding 16'hA55A -> rdata=8'hA5 at ack; with addr=22'h000000 -> rdata=8'h5A.
- Back-to-back write then read to addr=22'h3FFFFE -> exactly one IDLE cycle between them, ram_addr_o=21'h1FFFFF, and we_n/oe_n never overlap.
- Reset asserted during STROBE of a write -> we_n=1 and ce_n=1 immediately, no ack, and the next request completes normally.
- With SRAM_READ_CACHE_EN, read 22'h000010 twice -> the second ack arrives 1 cycle after acceptance with no ce_n activity. A write of 8'h77 to 22'h000011 followed by a read of 22'h000011 returns 8'h77 from the cache.
